// File: rtl/root_pkg.sv
// Shared constants and types for the three-channel brushed-DC motor controller.
package root_pkg;

  localparam int NCH = 3;

  localparam logic [3:0] ADDR_ZERO  = 4'hC;
  localparam logic [3:0] ADDR_HWCFG = 4'hD;
  localparam logic [3:0] ADDR_WDIV  = 4'hE;
  localparam logic [3:0] ADDR_WCTL  = 4'hF;

  localparam logic [1:0] SUB_DUTY_TACHLO = 2'd0;
  localparam logic [1:0] SUB_TACHHI      = 2'd1;
  localparam logic [1:0] SUB_CFG         = 2'd2;

  localparam logic [7:0] HWCONFIG      = 8'h30;
  localparam logic [7:0] WDIV_RESET    = 8'hFF;
  localparam int         WDOG_PRESCALE = 32;

  typedef enum logic [1:0] {
    DRV_OFF,
    DRV_FWD,
    DRV_REV,
    DRV_BRAKE
  } drive_t;

  // A divisor of zero stands for a full 256-tick timeout.
  function automatic logic [8:0] wdog_limit(input logic [7:0] div);
    return (div == 8'd0) ? 9'd256 : {1'b0, div};
  endfunction

endpackage

// File: rtl/bdc_channel.sv
// One motor channel: quadrature tach counter, duty/config registers and
// H-bridge output mapping with cycle-by-cycle current-limit blanking.
module bdc_channel
  import root_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] tach,
  input  logic       duty_we,
  input  logic       cfg_we,
  input  logic [7:0] wdata,
  input  logic       snap,
  input  logic [7:0] pwm_cnt,
  input  logic       pwm_wrap,
  input  logic       currentlimit,
  input  logic       active,
  output logic [7:0] tach_lo,
  output logic [7:0] snap_hi,
  output logic [7:0] cfg,
  output logic [1:0] pwm,
  output logic [3:0] pwm4
);

  logic [1:0]  tach_m, tach_s, tach_p;
  logic [1:0]  step;
  logic [15:0] count;
  logic [7:0]  duty;
  logic        blank;
  logic        p;
  drive_t      mode;

  // Position along the Gray cycle 00,01,11,10 so a step is a mod-4 difference.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign step    = gray_pos(tach_s) - gray_pos(tach_p);
  assign tach_lo = count[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      tach_m  <= 2'b00;
      tach_s  <= 2'b00;
      tach_p  <= 2'b00;
      count   <= 16'd0;
      snap_hi <= 8'd0;
      duty    <= 8'd0;
      cfg     <= 8'd0;
      blank   <= 1'b0;
    end else begin
      tach_m <= tach;
      tach_s <= tach_m;
      tach_p <= tach_s;
      if (step == 2'd1)
        count <= count + 16'd1;
      else if (step == 2'd3)
        count <= count - 16'd1;
      if (snap)
        snap_hi <= count[15:8];
      if (duty_we)
        duty <= wdata;
      if (cfg_we)
        cfg <= wdata;
      // Once limited, stay off for the rest of the PWM period.
      if (currentlimit)
        blank <= 1'b1;
      else if (pwm_wrap)
        blank <= 1'b0;
    end
  end

  assign p = (pwm_cnt < duty) & ~blank & ~currentlimit;

  always_comb begin
    mode = DRV_OFF;
    if (active) begin
      if (duty == 8'd0 && cfg[1])
        mode = DRV_BRAKE;
      else if (cfg[0])
        mode = DRV_REV;
      else
        mode = DRV_FWD;
    end
  end

  // pwm4 is {LB, HB, LA, HA}; pwm is {rev, fwd}.
  always_comb begin
    pwm  = 2'b00;
    pwm4 = 4'b0000;
    case (mode)
      DRV_FWD: begin
        pwm  = {1'b0, p};
        pwm4 = {1'b1, 1'b0, 1'b0, p};
      end
      DRV_REV: begin
        pwm  = {p, 1'b0};
        pwm4 = {1'b0, p, 1'b1, 1'b0};
      end
      DRV_BRAKE: pwm4 = 4'b1010;
      default: ;
    endcase
  end

endmodule

// File: rtl/root.sv
// Motor controller top: SPI slave register file, shared PWM timebase,
// watchdog, and three bdc_channel instances.
module root
  import root_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       ssn,
  input  logic       mosi,
  output logic       miso,
  input  logic       tstn,
  input  logic       wdogdisn,
  input  logic       currentlimit0,
  input  logic       currentlimit1,
  input  logic       currentlimit2,
  input  logic [1:0] tach0,
  input  logic [1:0] tach1,
  input  logic [1:0] tach2,
  output logic [1:0] pwm0,
  output logic [1:0] pwm1,
  output logic [1:0] pwm2,
  output logic [3:0] pwm40,
  output logic [3:0] pwm41,
  output logic [3:0] pwm42,
  output logic       motorena
);

  localparam int PRE_W = $clog2(WDOG_PRESCALE);

  logic [1:0] sclk_sync, ssn_sync, mosi_sync;
  logic       sclk_d, sclk_s, ssn_s, mosi_s, sclk_rise;
  logic [4:0] bitcnt;
  logic [6:0] shreg;
  logic [7:0] rx_byte, tx, rdata;
  logic [3:0] cmd_addr, addr_q;
  logic       rd_q, spi_bit, cmd_done, wr_commit;

  logic [7:0]       wdiv;
  logic [3:0]       wctl;
  logic             trip, wdog_run;
  logic [PRE_W-1:0] wpre;
  logic [8:0]       ticks;

  logic [3:0] pwm_pre;
  logic [7:0] pwm_cnt;
  logic       pwm_step, pwm_wrap;

  logic [1:0] tach_a [NCH];
  logic       cl_a   [NCH];
  logic [1:0] pwm_a  [NCH];
  logic [3:0] pwm4_a [NCH];
  logic [7:0] tach_lo[NCH];
  logic [7:0] snap_hi[NCH];
  logic [7:0] cfg    [NCH];

  assign sclk_s    = sclk_sync[1];
  assign ssn_s     = ssn_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign rx_byte   = {shreg, mosi_s};
  assign cmd_addr  = rx_byte[6:3];
  assign spi_bit   = sclk_rise & ~ssn_s & (bitcnt != 5'd16);
  assign cmd_done  = spi_bit & (bitcnt == 5'd7);
  assign wr_commit = spi_bit & (bitcnt == 5'd15) & ~rd_q;

  assign miso = ssn ? 1'bz : tx[7];

  // Bits 1-8 form the command; bits 9-16 are write data or read shift-out.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= 2'b11;
      ssn_sync  <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b1;
      bitcnt    <= 5'd0;
      shreg     <= 7'd0;
      rd_q      <= 1'b0;
      addr_q    <= 4'd0;
      tx        <= 8'd0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      ssn_sync  <= {ssn_sync[0], ssn};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_s;
      if (ssn_s) begin
        bitcnt <= 5'd0;
        tx     <= 8'd0;
      end else if (spi_bit) begin
        bitcnt <= bitcnt + 5'd1;
        shreg  <= rx_byte[6:0];
        if (bitcnt == 5'd7) begin
          rd_q   <= rx_byte[7];
          addr_q <= cmd_addr;
          tx     <= rx_byte[7] ? rdata : 8'd0;
        end else if (bitcnt >= 5'd8) begin
          tx <= {tx[6:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    rdata = 8'd0;
    if (cmd_addr[3:2] == 2'd3) begin
      case (cmd_addr)
        ADDR_HWCFG: rdata = HWCONFIG;
        ADDR_WDIV:  rdata = wdiv;
        ADDR_WCTL:  rdata = {trip, 3'b000, wctl};
        default:    rdata = 8'd0;
      endcase
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (cmd_addr[3:2] == n[1:0]) begin
          case (cmd_addr[1:0])
            SUB_DUTY_TACHLO: rdata = tach_lo[n];
            SUB_TACHHI:      rdata = snap_hi[n];
            SUB_CFG:         rdata = cfg[n];
            default:         rdata = 8'd0;
          endcase
        end
      end
    end
  end

  assign wdog_run = wctl[3] & wdogdisn & ~trip;
  assign motorena = wctl[3] & ~trip;

  // A control write both restarts the count and outranks a same-cycle trip.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdiv  <= WDIV_RESET;
      wctl  <= 4'd0;
      trip  <= 1'b0;
      wpre  <= '0;
      ticks <= 9'd0;
    end else begin
      if (wr_commit && addr_q == ADDR_WDIV)
        wdiv <= rx_byte;
      if (wr_commit && addr_q == ADDR_WCTL) begin
        wctl  <= rx_byte[3:0];
        wpre  <= '0;
        ticks <= 9'd0;
        if (rx_byte[7])
          trip <= 1'b0;
      end else if (!wdog_run) begin
        wpre  <= '0;
        ticks <= 9'd0;
      end else begin
        wpre <= wpre + 1'b1;
        if (wpre == PRE_W'(WDOG_PRESCALE - 1)) begin
          ticks <= ticks + 9'd1;
          if (ticks + 9'd1 == wdog_limit(wdiv))
            trip <= 1'b1;
        end
      end
    end
  end

  assign pwm_step = ~tstn | (pwm_pre == 4'hF);
  assign pwm_wrap = pwm_step & (pwm_cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_pre <= 4'd0;
      pwm_cnt <= 8'd0;
    end else begin
      pwm_pre <= pwm_pre + 4'd1;
      if (pwm_step)
        pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign tach_a[0] = tach0;
  assign tach_a[1] = tach1;
  assign tach_a[2] = tach2;
  assign cl_a[0]   = currentlimit0;
  assign cl_a[1]   = currentlimit1;
  assign cl_a[2]   = currentlimit2;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    bdc_channel u_ch (
      .clk          (clk),
      .reset        (reset),
      .tach         (tach_a[g]),
      .duty_we      (wr_commit && addr_q == {2'(g), SUB_DUTY_TACHLO}),
      .cfg_we       (wr_commit && addr_q == {2'(g), SUB_CFG}),
      .wdata        (rx_byte),
      .snap         (cmd_done && rx_byte[7] && cmd_addr == {2'(g), SUB_DUTY_TACHLO}),
      .pwm_cnt      (pwm_cnt),
      .pwm_wrap     (pwm_wrap),
      .currentlimit (cl_a[g]),
      .active       (wctl[g] & motorena),
      .tach_lo      (tach_lo[g]),
      .snap_hi      (snap_hi[g]),
      .cfg          (cfg[g]),
      .pwm          (pwm_a[g]),
      .pwm4         (pwm4_a[g])
    );
  end

  assign pwm0  = pwm_a[0];
  assign pwm1  = pwm_a[1];
  assign pwm2  = pwm_a[2];
  assign pwm40 = pwm4_a[0];
  assign pwm41 = pwm4_a[1];
  assign pwm42 = pwm4_a[2];

endmodule

// File: tb/tb_root.sv
// Self-checking bench for root: SPI register access, tach, PWM, current limit
// and watchdog, checked against a register-level model of the controller.
module tb_root;

  logic       clk = 1'b0;
  logic       reset, sclk, ssn, mosi, tstn, wdogdisn;
  logic       currentlimit0, currentlimit1, currentlimit2;
  logic [1:0] tach0, tach1, tach2;
  logic [1:0] pwm0, pwm1, pwm2;
  logic [3:0] pwm40, pwm41, pwm42;
  logic       motorena;
  wire        miso;

  logic [1:0] tachIn [3];
  assign tach0 = tachIn[0];
  assign tach1 = tachIn[1];
  assign tach2 = tachIn[2];

  int nCompared = 0;
  int nMismatched = 0;

  int         tachModel [3];
  logic [7:0] snapModel [3];
  logic [7:0] cfgModel  [3];
  logic [7:0] divModel;
  logic [3:0] ctlModel;
  logic       tripModel;

  root dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ssn(ssn), .mosi(mosi), .miso(miso),
    .tstn(tstn), .wdogdisn(wdogdisn),
    .currentlimit0(currentlimit0), .currentlimit1(currentlimit1), .currentlimit2(currentlimit2),
    .tach0(tach0), .tach1(tach1), .tach2(tach2),
    .pwm0(pwm0), .pwm1(pwm1), .pwm2(pwm2),
    .pwm40(pwm40), .pwm41(pwm41), .pwm42(pwm42),
    .motorena(motorena)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spiXfer(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                         output logic [7:0] rd);
    logic [15:0] frame;
    frame = {b0, b1};
    rd = 8'h00;
    ssn = 1'b0;
    waitClk(4);
    for (int i = 15; i >= 16 - nbits; i--) begin
      sclk = 1'b0;
      mosi = frame[i];
      waitClk(4);
      if (i < 8) rd[i] = miso;
      sclk = 1'b1;
      waitClk(4);
    end
    ssn = 1'b1;
    mosi = 1'b0;
    waitClk(6);
  endtask

  function automatic logic [7:0] modelRead(input logic [3:0] a);
    if (a >= 4'hC) begin
      case (a)
        4'hD:    return 8'h30;
        4'hE:    return divModel;
        4'hF:    return {tripModel, 3'b000, ctlModel};
        default: return 8'h00;
      endcase
    end
    case (a % 4)
      0:       return 8'((tachModel[a / 4] & 16'hFFFF) % 256);
      1:       return snapModel[a / 4];
      2:       return cfgModel[a / 4];
      default: return 8'h00;
    endcase
  endfunction

  task automatic spiWrite(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    spiXfer({1'b0, a, 3'b000}, d, 16, dummy);
    if (a == 4'hE) divModel = d;
    else if (a == 4'hF) begin
      ctlModel = d[3:0];
      if (d[7]) tripModel = 1'b0;
    end else if (a < 4'hC && a % 4 == 2) cfgModel[a / 4] = d;
  endtask

  task automatic checkRead(input string tag, input logic [3:0] a);
    logic [7:0] exp, got;
    exp = modelRead(a);
    spiXfer({1'b1, a, 3'b000}, 8'h00, 16, got);
    checkOutput(tag, {8'h00, got}, {8'h00, exp});
    if (a < 4'hC && a % 4 == 0)
      snapModel[a / 4] = 8'(((tachModel[a / 4] & 16'hFFFF) / 256));
  endtask

  function automatic logic [1:0] grayNext(input logic [1:0] g);
    case (g)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Forward Gray step counts up, backward step counts down, anything else holds.
  task automatic applyStimulus(input int ch, input logic [1:0] v);
    logic [1:0] old;
    old = tachIn[ch];
    tachIn[ch] = v;
    if (v == grayNext(old)) tachModel[ch]++;
    else if (old == grayNext(v)) tachModel[ch]--;
    waitClk(6);
  endtask

  function automatic logic [1:0] getPwm(input int ch);
    return (ch == 0) ? pwm0 : (ch == 1) ? pwm1 : pwm2;
  endfunction

  function automatic logic [3:0] getPwm4(input int ch);
    return (ch == 0) ? pwm40 : (ch == 1) ? pwm41 : pwm42;
  endfunction

  task automatic measurePwm(input int ch, input bit rev, input int n,
                            output int highs, output int bad);
    logic [1:0] pw;
    logic [3:0] p4;
    logic       p;
    highs = 0;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      waitClk(1);
      pw = getPwm(ch);
      p4 = getPwm4(ch);
      p = rev ? pw[1] : pw[0];
      if (p === 1'b1) highs++;
      if (rev) begin
        if (pw !== {p, 1'b0} || p4 !== {1'b0, p, 1'b1, 1'b0}) bad++;
      end else begin
        if (pw !== {1'b0, p} || p4 !== {1'b1, 1'b0, 1'b0, p}) bad++;
      end
    end
  endtask

  initial begin
    logic [7:0] rd, d;
    logic [3:0] a;
    int highs, bad, hiBefore, hiAfter;
    logic [7:0] planDuty [3];
    logic [1:0] planTach [6];
    logic [7:0] planLo [6];
    logic [7:0] planHi [6];
    bit found;
    logic prev;

    planDuty = '{8'h40, 8'hC0, 8'h80};
    planTach = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b00};
    planLo   = '{8'h01, 8'h02, 8'h01, 8'h00, 8'hFF, 8'h00};
    planHi   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};

    reset = 1'b1; sclk = 1'b1; ssn = 1'b1; mosi = 1'b0; tstn = 1'b1; wdogdisn = 1'b0;
    currentlimit0 = 1'b0; currentlimit1 = 1'b0; currentlimit2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tachIn[i] = 2'b00; tachModel[i] = 0; snapModel[i] = 8'h00; cfgModel[i] = 8'h00;
    end
    divModel = 8'hFF; ctlModel = 4'h0; tripModel = 1'b0;
    waitClk(5);
    reset = 1'b0;
    waitClk(5);

    checkOutput("rst_miso_z", {15'd0, miso === 1'bz}, 16'd1);
    checkOutput("rst_motorena", {15'd0, motorena}, 16'd0);
    checkOutput("rst_pwm", {pwm0, pwm1, pwm2, pwm40}, 16'd0);
    checkRead("rd_hwcfg", 4'hD);
    checkRead("rd_div_rst", 4'hE);
    checkRead("rd_ctl_rst", 4'hF);
    checkRead("rd_tach_rst", 4'h0);
    checkRead("rd_b3", 4'h3);
    checkRead("rd_c", 4'hC);

    spiWrite(4'h2, 8'h01);
    spiWrite(4'h6, 8'h02);
    spiWrite(4'hA, 8'h04);
    checkRead("cfg0", 4'h2);
    checkRead("cfg1", 4'h6);
    checkRead("cfg2", 4'hA);

    spiXfer({1'b0, 4'h2, 3'b000}, 8'hAA, 15, rd);
    checkRead("short_frame", 4'h2);
    checkOutput("miso_z_idle", {15'd0, miso === 1'bz}, 16'd1);

    for (int i = 0; i < 20; i++) begin
      a = 4'($urandom_range(0, 14));
      d = 8'($urandom);
      spiWrite(a, d);
      a = 4'($urandom_range(0, 14));
      checkRead("rand_reg", a);
    end

    for (int ch = 0; ch < 3; ch++) begin
      for (int s = 0; s < 6; s++) begin
        applyStimulus(ch, planTach[s]);
        spiXfer({1'b1, 4'(ch * 4), 3'b000}, 8'h00, 16, rd);
        checkOutput("tach_lo_plan", {8'h00, rd}, {8'h00, planLo[s]});
        spiXfer({1'b1, 4'(ch * 4 + 1), 3'b000}, 8'h00, 16, rd);
        checkOutput("tach_hi_plan", {8'h00, rd}, {8'h00, planHi[s]});
      end
      snapModel[ch] = 8'h00;
    end

    for (int i = 0; i < 30; i++) begin
      applyStimulus($urandom_range(0, 2), 2'($urandom_range(0, 3)));
      if (i % 5 == 4) begin
        a = 4'($urandom_range(0, 2) * 4);
        checkRead("tach_rand_lo", a);
        checkRead("tach_rand_hi", a + 4'd1);
      end
    end

    spiWrite(4'hF, 8'h0F);
    checkOutput("motorena_on", {15'd0, motorena}, 16'd1);
    tstn = 1'b0;
    spiWrite(4'h2, 8'h00);
    for (int i = 0; i < 5; i++) begin
      d = (i < 3) ? planDuty[i] : 8'($urandom);
      spiWrite(4'h0, d);
      measurePwm(0, 1'b0, 256, highs, bad);
      checkOutput("pwm0_high", 16'(highs), {8'h00, d});
      checkOutput("pwm0_shape", 16'(bad), 16'd0);
    end

    spiWrite(4'h6, 8'h01);
    d = 8'($urandom_range(1, 255));
    spiWrite(4'h4, d);
    measurePwm(1, 1'b1, 256, highs, bad);
    checkOutput("pwm1_rev_high", 16'(highs), {8'h00, d});
    checkOutput("pwm1_rev_shape", 16'(bad), 16'd0);

    spiWrite(4'h8, 8'h00);
    spiWrite(4'hA, 8'h02);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      waitClk(1);
      if (pwm42 !== 4'b1010 || pwm2 !== 2'b00) bad++;
    end
    checkOutput("brake", 16'(bad), 16'd0);
    spiWrite(4'h8, 8'h20);
    measurePwm(2, 1'b0, 256, highs, bad);
    checkOutput("brake_nonzero_duty", 16'(highs), 16'h20);

    spiWrite(4'hF, 8'h0B);
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      waitClk(1);
      if (pwm42 !== 4'b0000 || pwm2 !== 2'b00) bad++;
    end
    checkOutput("inactive_ch2", 16'(bad), 16'd0);

    tstn = 1'b1;
    spiWrite(4'h0, 8'h80);
    measurePwm(0, 1'b0, 4096, highs, bad);
    checkOutput("pwm0_slow", 16'(highs), 16'd2048);
    tstn = 1'b0;

    found = 1'b0;
    prev = 1'b1;
    for (int k = 0; k < 600 && !found; k++) begin
      waitClk(1);
      if (pwm0[0] === 1'b1 && prev === 1'b0) found = 1'b1;
      prev = pwm0[0];
    end
    checkOutput("cl_sync", {15'd0, found}, 16'd1);
    if (found) begin
      hiBefore = 0;
      hiAfter = 0;
      for (int k = 1; k < 256; k++) begin
        waitClk(1);
        if (k <= 10) hiBefore += int'(pwm0[0] === 1'b1);
        else hiAfter += int'(pwm0 !== 2'b00);
        if (k == 10) currentlimit0 = 1'b1;
        if (k == 15) currentlimit0 = 1'b0;
      end
      checkOutput("cl_before", 16'(hiBefore), 16'd10);
      checkOutput("cl_blanked", 16'(hiAfter), 16'd0);
      waitClk(1);
      checkOutput("cl_wrap_on", {15'd0, pwm0[0]}, 16'd1);
    end

    spiWrite(4'hE, 8'h10);
    spiWrite(4'hF, 8'h07);
    checkRead("wdog_ctl07", 4'hF);
    wdogdisn = 1'b1;
    spiWrite(4'hF, 8'h0F);
    waitClk(440);
    checkOutput("wdog_pretrip", {15'd0, motorena}, 16'd1);
    waitClk(140);
    checkOutput("wdog_trip", {15'd0, motorena}, 16'd0);
    tripModel = 1'b1;
    waitClk(670);
    checkRead("wdog_flag", 4'hF);
    checkOutput("wdog_gate", {pwm0, pwm40}, 16'd0);
    spiWrite(4'hF, 8'h80);
    spiWrite(4'hF, 8'h0F);
    checkRead("wdog_clear", 4'hF);
    checkOutput("wdog_reena", {15'd0, motorena}, 16'd1);
    checkOutput("miso_z_end", {15'd0, miso === 1'bz}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
